// File: rtl/ula_nbits_seq_if.sv
// Operand/result bundle of the sequential ULA.
// master drives operands and start; slave returns results and flags.
interface ula_nbits_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       operacao;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] resultado;
    logic [WIDTH-1:0] resultado_alto;
    logic             overflow;
    logic             zero;
    logic             carry_out;
    logic             erro;

    modport master (
        output start, a, b, operacao,
        input  busy, done, resultado, resultado_alto,
        input  overflow, zero, carry_out, erro
    );

    modport slave (
        input  start, a, b, operacao,
        output busy, done, resultado, resultado_alto,
        output overflow, zero, carry_out, erro
    );
endinterface

// File: rtl/ula_nbits_seq.sv
// Registered WIDTH-bit ULA: one-cycle add/sub/logic,
// iterative shift-add multiply and restoring divide.
module ula_nbits_seq #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    ula_nbits_seq_if.slave  bus
);
    localparam int MSB = WIDTH - 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIM  = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2:0]         op_q;
    logic               load;

    logic [WIDTH-1:0]   res_q, hi_q;
    logic               ovf_q, zero_q, cy_q, err_q;
    logic [WIDTH-1:0]   res_c, hi_c;
    logic               ovf_c, cy_c, err_c;

    logic [WIDTH:0]     sum, diff, msum, rem, rem_s;
    logic               rge;
    logic [2*WIDTH-1:0] macc, dacc;

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    // mul: acc = {partial product, remaining multiplier bits}
    assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
    assign macc = acc_q[0] ? {msum, acc_q[WIDTH-1:1]}
                           : {1'b0, acc_q[2*WIDTH-1:1]};

    // div: acc = {partial remainder, dividend shifting into quotient}
    assign rem   = {acc_q[2*WIDTH-1:WIDTH], acc_q[MSB]};
    assign rge   = rem >= {1'b0, b_q};
    assign rem_s = rge ? rem - {1'b0, b_q} : rem;
    assign dacc  = {rem_s[WIDTH-1:0], acc_q[WIDTH-2:0], rge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    load = 1'b1;
                    if (bus.operacao == OP_MUL ||
                        (bus.operacao == OP_DIV && bus.b != '0)) begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        acc_d   = (bus.operacao == OP_MUL)
                                ? {{WIDTH{1'b0}}, bus.b}
                                : {{WIDTH{1'b0}}, bus.a};
                    end else begin
                        state_d = S_FIM;
                    end
                end
            end
            S_CALC: begin
                acc_d = (op_q == OP_MUL) ? macc : dacc;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIM;
                    busy_d  = 1'b0;
                end
            end
            S_FIM: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        res_c = '0;
        hi_c  = '0;
        ovf_c = 1'b0;
        cy_c  = 1'b0;
        err_c = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                res_c = sum[WIDTH-1:0];
                cy_c  = sum[WIDTH];
                ovf_c = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                res_c = diff[WIDTH-1:0];
                cy_c  = diff[WIDTH];
                err_c = diff[WIDTH];
                ovf_c = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
            end
            OP_MUL: begin
                res_c = acc_q[WIDTH-1:0];
                hi_c  = acc_q[2*WIDTH-1:WIDTH];
                ovf_c = |acc_q[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    hi_c  = a_q;
                    err_c = 1'b1;
                end else begin
                    res_c = acc_q[WIDTH-1:0];
                    hi_c  = acc_q[2*WIDTH-1:WIDTH];
                end
            end
            OP_AND: res_c = a_q & b_q;
            OP_OR:  res_c = a_q | b_q;
            OP_XOR: res_c = a_q ^ b_q;
            OP_NOT: res_c = ~a_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            cy_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (load) begin
                a_q  <= bus.a;
                b_q  <= bus.b;
                op_q <= bus.operacao;
            end
            if (state_q == S_FIM) begin
                res_q  <= res_c;
                hi_q   <= hi_c;
                ovf_q  <= ovf_c;
                zero_q <= (res_c == '0);
                cy_q   <= cy_c;
                err_q  <= err_c;
            end
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.resultado      = res_q;
    assign bus.resultado_alto = hi_q;
    assign bus.overflow       = ovf_q;
    assign bus.zero           = zero_q;
    assign bus.carry_out      = cy_q;
    assign bus.erro           = err_q;
endmodule

// File: tb/tb_ula_nbits_seq.sv
// Scoreboard bench for ula_nbits_seq at WIDTH=8 and WIDTH=16.
// Expected results come from plain integer arithmetic.
module tb_ula_nbits_seq;
    typedef struct {
        longint unsigned res;
        longint unsigned hi;
        bit              ovf;
        bit              zero;
        bit              cy;
        bit              err;
        int              lat;
        int              busy;
        longint          t0;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_bad = 0;
    int     dcnt [2];
    int     bcnt [2];
    exp_t   q8 [$];
    exp_t   q16 [$];

    ula_nbits_seq_if #(.WIDTH(8))  i8 ();
    ula_nbits_seq_if #(.WIDTH(16)) i16 ();

    ula_nbits_seq #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(i8));
    ula_nbits_seq #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(i16));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(string nm, longint unsigned act, longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(int w, longint unsigned a,
                                   longint unsigned b, logic [2:0] op);
        exp_t e;
        longint unsigned m = (64'd1 << w) - 1;
        longint unsigned t;
        int msb = w - 1;
        e.res = 0; e.hi = 0; e.ovf = 0; e.cy = 0; e.err = 0;
        e.lat = 1; e.busy = 0; e.t0 = 0;
        case (op)
            3'd0: begin
                t = a + b;
                e.res = t & m;
                e.cy  = ((t >> w) & 1) != 0;
                e.ovf = (a[msb] == b[msb]) && (e.res[msb] != a[msb]);
            end
            3'd1: begin
                e.res = (a - b) & m;
                e.cy  = a < b;
                e.err = a < b;
                e.ovf = (a[msb] != b[msb]) && (e.res[msb] != a[msb]);
            end
            3'd2: begin
                t = a * b;
                e.res = t & m;
                e.hi  = t >> w;
                e.ovf = e.hi != 0;
                e.lat = w + 1;
                e.busy = w;
            end
            3'd3: begin
                if (b == 0) begin
                    e.hi  = a;
                    e.err = 1;
                end else begin
                    e.res = a / b;
                    e.hi  = a % b;
                    e.lat = w + 1;
                    e.busy = w;
                end
            end
            3'd4: e.res = a & b;
            3'd5: e.res = a | b;
            3'd6: e.res = a ^ b;
            default: e.res = ~a & m;
        endcase
        e.zero = e.res == 0;
        return e;
    endfunction

    task automatic get_out(int sel, output longint unsigned res,
                           output longint unsigned hi, output bit bsy,
                           output bit dn, output bit ovf, output bit zr,
                           output bit cy, output bit er);
        if (sel == 0) begin
            res = 64'(i8.resultado); hi = 64'(i8.resultado_alto);
            bsy = i8.busy; dn = i8.done; ovf = i8.overflow;
            zr = i8.zero; cy = i8.carry_out; er = i8.erro;
        end else begin
            res = 64'(i16.resultado); hi = 64'(i16.resultado_alto);
            bsy = i16.busy; dn = i16.done; ovf = i16.overflow;
            zr = i16.zero; cy = i16.carry_out; er = i16.erro;
        end
    endtask

    task automatic on_done(int sel);
        exp_t e;
        longint unsigned res, hi;
        bit bsy, dn, ovf, zr, cy, er;
        dcnt[sel]++;
        get_out(sel, res, hi, bsy, dn, ovf, zr, cy, er);
        if ((sel == 0 ? q8.size() : q16.size()) == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done w%0d: got done with nothing expected",
                     sel == 0 ? 8 : 16);
            return;
        end
        e = (sel == 0) ? q8.pop_front() : q16.pop_front();
        cmp("resultado", res, e.res);
        cmp("resultado_alto", hi, e.hi);
        cmp("overflow", 64'(ovf), 64'(e.ovf));
        cmp("zero", 64'(zr), 64'(e.zero));
        cmp("carry_out", 64'(cy), 64'(e.cy));
        cmp("erro", 64'(er), 64'(e.err));
        cmp("latency", 64'(cyc - e.t0 - 1), 64'(e.lat));
        cmp("busy_cycles", 64'(bcnt[sel]), 64'(e.busy));
        cmp("busy_at_done", 64'(bsy), 64'd0);
        bcnt[sel] = 0;
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (i8.busy) bcnt[0]++;
            if (i16.busy) bcnt[1]++;
            if (i8.done) on_done(0);
            if (i16.done) on_done(1);
        end
    end

    task automatic drive(int sel, logic s, longint unsigned a,
                         longint unsigned b, logic [2:0] op);
        if (sel == 0) begin
            i8.start = s; i8.a = a[7:0]; i8.b = b[7:0]; i8.operacao = op;
        end else begin
            i16.start = s; i16.a = a[15:0]; i16.b = b[15:0]; i16.operacao = op;
        end
    endtask

    task automatic issue(int sel, longint unsigned a, longint unsigned b,
                         logic [2:0] op, int pulse);
        exp_t e = model(sel == 0 ? 8 : 16, a, b, op);
        int d0 = dcnt[sel];
        int k = 0;
        @(negedge clk);
        e.t0 = cyc;
        if (sel == 0) q8.push_back(e); else q16.push_back(e);
        drive(sel, 1'b1, a, b, op);
        @(negedge clk);
        drive(sel, 1'b0, a, b, op);
        while (dcnt[sel] == d0 && k < 40) begin
            @(negedge clk);
            if (pulse > 0 && k == pulse)
                drive(sel, 1'b1, 64'($urandom), 64'($urandom), 3'($urandom));
            if (pulse > 0 && k == pulse + 1)
                drive(sel, 1'b0, 64'($urandom), 64'($urandom), 3'($urandom));
            k++;
        end
        if (dcnt[sel] == d0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout w%0d op%0d: no done within 40 cycles",
                     sel == 0 ? 8 : 16, op);
            if (sel == 0) void'(q8.pop_front()); else void'(q16.pop_front());
            bcnt[sel] = 0;
        end
        if (pulse > 0) begin
            repeat (4) @(negedge clk);
            cmp("single_done", 64'(dcnt[sel] - d0), 64'd1);
        end
    endtask

    task automatic check_reset(int sel);
        longint unsigned res, hi;
        bit bsy, dn, ovf, zr, cy, er;
        get_out(sel, res, hi, bsy, dn, ovf, zr, cy, er);
        cmp("rst_resultado", res, 0);
        cmp("rst_resultado_alto", hi, 0);
        cmp("rst_busy", 64'(bsy), 0);
        cmp("rst_done", 64'(dn), 0);
        cmp("rst_overflow", 64'(ovf), 0);
        cmp("rst_zero", 64'(zr), 1);
        cmp("rst_carry_out", 64'(cy), 0);
        cmp("rst_erro", 64'(er), 0);
    endtask

    initial begin
        int d0;
        logic [2:0] op;
        longint unsigned a, b;
        dcnt[0] = 0; dcnt[1] = 0; bcnt[0] = 0; bcnt[1] = 0;
        drive(0, 1'b0, 0, 0, 3'd0);
        drive(1, 1'b0, 0, 0, 3'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst = 1'b0;

        issue(0, 100, 100, 3'd0, 0);
        issue(0, 5, 10, 3'd1, 0);
        issue(0, 8'h80, 8'h80, 3'd0, 0);
        issue(0, 20, 15, 3'd2, 0);
        issue(0, 255, 255, 3'd2, 0);
        issue(0, 200, 7, 3'd3, 0);
        issue(0, 9, 0, 3'd3, 0);
        issue(0, 8'hA5, 0, 3'd7, 0);
        issue(0, 8'hFF, 8'hFF, 3'd7, 0);
        issue(0, 20, 15, 3'd2, 3);
        issue(1, 300, 300, 3'd2, 0);
        issue(1, 16'hFFFF, 16'h0003, 3'd3, 0);

        // start a divide, then pull reset in its fourth busy cycle
        @(negedge clk);
        d0 = dcnt[0];
        drive(0, 1'b1, 200, 7, 3'd3);
        @(negedge clk);
        drive(0, 1'b0, 200, 7, 3'd3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset(0);
        rst = 1'b0;
        bcnt[0] = 0;
        bcnt[1] = 0;
        repeat (15) @(negedge clk);
        cmp("no_done_after_rst", 64'(dcnt[0] - d0), 0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = 64'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : 64'($urandom_range(0, 255));
            issue(0, a, b, op, 0);
        end
        for (int i = 0; i < 20; i++) begin
            op = 3'($urandom_range(0, 7));
            a = 64'($urandom_range(0, 65535));
            b = ($urandom_range(0, 7) == 0) ? 0 : 64'($urandom_range(0, 65535));
            issue(1, a, b, op, 0);
        end

        repeat (5) @(negedge clk);
        cmp("q8_drained", 64'(q8.size()), 0);
        cmp("q16_drained", 64'(q16.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
